// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchronizer/debounce bank.
// The edge-pulse outputs are built only when SYNC_DB_EDGE_EN is defined.
package sync_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_DB_DEF     = 4;

  // Counter width able to hold 0..db; a single bit is the floor.
  function automatic int cnt_width(input int db);
    return (db < 1) ? 1 : $clog2(db + 1);
  endfunction

  localparam int SYNC_CNT_W_DEF = $clog2(SYNC_DB_DEF + 1);
  typedef logic [SYNC_CNT_W_DEF-1:0] db_cnt_def_t;

endpackage

// File: rtl/sync_db_chan.sv
// One channel: STAGES-deep synchronizer chain, debounce counter and stable level.
// SYNC_DB_EDGE_EN adds registered rise/fall pulses; otherwise they are tied low.
module sync_db_chan
  import sync_pkg::*;
#(
  parameter int   STAGES    = SYNC_STAGES_DEF,
  parameter int   DB_CYCLES = SYNC_DB_DEF,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DB_CYCLES);
  typedef logic [CNT_W-1:0] db_cnt_t;
  localparam db_cnt_t CNT_MAX = db_cnt_t'(DB_CYCLES - 1);

  logic [STAGES-1:0] r_chain;
  db_cnt_t           r_cnt;
  db_cnt_t           w_cnt_next;
  logic              r_q;
  logic              w_q_next;
  logic              w_s;

  assign w_s = r_chain[STAGES-1];

  // Plain shift chain: nothing may sit between the metastability flops.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) r_chain <= {STAGES{RST_VAL}};
    else          r_chain <= {r_chain[STAGES-2:0], d};
  end

  always_comb begin
    w_q_next   = r_q;
    w_cnt_next = '0;
    if (w_s != r_q) begin
      if (r_cnt == CNT_MAX) w_q_next   = w_s;
      else                  w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q   <= RST_VAL;
      r_cnt <= '0;
    end else begin
      r_q   <= w_q_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign q = r_q;

`ifdef SYNC_DB_EDGE_EN
  logic r_rise;
  logic r_fall;

  // Pulses come from the same edge that updates the level, so they line up with q.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_q_next & ~r_q;
      r_fall <= ~w_q_next & r_q;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of N_CH independent synchronize-and-debounce channels with per-channel reset value.
// Edge pulses exist only when SYNC_DB_EDGE_EN is defined.
module sync_debounce_bank
  import sync_pkg::*;
#(
  parameter int              N_CH      = 8,
  parameter int              STAGES    = SYNC_STAGES_DEF,
  parameter int              DB_CYCLES = SYNC_DB_DEF,
  parameter logic [N_CH-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            Reset_n,
  input  logic [N_CH-1:0] d,
  output logic [N_CH-1:0] q,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    sync_db_chan #(
      .STAGES    (STAGES),
      .DB_CYCLES (DB_CYCLES),
      .RST_VAL   (RESET_VAL[g])
    ) u_chan (
      .clk     (clk),
      .Reset_n (Reset_n),
      .d       (d[g]),
      .q       (q[g]),
      .rise    (rise[g]),
      .fall    (fall[g])
    );
  end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Scoreboard bench for sync_debounce_bank: window-based reference model, expectations queued per cycle.
module tb_sync_debounce_bank;

  localparam int          N  = 8;
  localparam int          ST = 2;
  localparam int          DB = 4;
  localparam logic [N-1:0] RV = 8'hA5;
`ifdef SYNC_DB_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic [N-1:0] d = RV;
  logic [N-1:0] q, rise, fall;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] hist[$];
  logic [N-1:0] m_q;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  sync_debounce_bank #(
    .N_CH      (N),
    .STAGES    (ST),
    .DB_CYCLES (DB),
    .RESET_VAL (RV)
  ) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .d       (d),
    .q       (q),
    .rise    (rise),
    .fall    (fall)
  );

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // History of captured d values; pre-reset samples read as the reset value.
  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < ST + DB; i++) hist.push_back(RV);
    m_q = RV;
  endtask

  // Level flips when the last DB synchronized samples all disagree with it.
  // The sample seen by the debouncer at edge e is the d captured at edge e-ST.
  task automatic model_edge(input logic [N-1:0] dv, output exp_t e);
    logic [N-1:0] nq;
    hist.push_back(dv);
    if (hist.size() > ST + DB) void'(hist.pop_front());
    nq = m_q;
    for (int ch = 0; ch < N; ch++) begin
      bit flip = 1'b1;
      for (int j = 0; j < DB; j++)
        if (hist[hist.size() - 1 - ST - j][ch] == m_q[ch]) flip = 1'b0;
      if (flip) nq[ch] = ~m_q[ch];
    end
    e.q    = nq;
    e.rise = EDGE_EN ? (nq & ~m_q) : '0;
    e.fall = EDGE_EN ? (~nq & m_q) : '0;
    m_q    = nq;
  endtask

  task automatic step(input logic [N-1:0] dv, input bit rst);
    exp_t e;
    @(negedge clk);
    Reset_n = ~rst;
    d       = dv;
    if (rst) begin
      model_reset();
      e.q = RV; e.rise = '0; e.fall = '0;
      #1;
      chk("q_async_reset", q, RV);
      chk("edge_in_reset", rise | fall, '0);
    end else begin
      model_edge(dv, e);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compares every cycle the bench has queued an expectation for.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q", q, e.q);
        chk("rise", rise, e.rise);
        chk("fall", fall, e.fall);
      end
    end
  end

  initial begin
    logic [N-1:0] dv;
    model_reset();

    // Reset held with d toggling
    for (int i = 0; i < 6; i++) step(N'($urandom), 1'b1);
    dv = RV;
    for (int i = 0; i < 8; i++) step(dv, 1'b0);

    // Clean steps on channel 0
    dv[0] = 1'b0;
    for (int i = 0; i < 10; i++) step(dv, 1'b0);
    dv[0] = 1'b1;
    for (int i = 0; i < 10; i++) step(dv, 1'b0);

    // Three-cycle glitch on channel 1
    dv[1] = 1'b1;
    for (int i = 0; i < 3; i++) step(dv, 1'b0);
    dv[1] = 1'b0;
    for (int i = 0; i < 10; i++) step(dv, 1'b0);

    // Chatter on channel 2: bring it low, then 1,0,1,1,1,1
    dv[2] = 1'b0;
    for (int i = 0; i < 10; i++) step(dv, 1'b0);
    for (int i = 0; i < 6; i++) begin
      dv[2] = (i != 1);
      step(dv, 1'b0);
    end
    for (int i = 0; i < 8; i++) step(dv, 1'b0);

    // Channel 3 step interrupted by reset after two counted cycles
    dv[3] = 1'b1;
    for (int i = 0; i < 4; i++) step(dv, 1'b0);
    for (int i = 0; i < 2; i++) step(dv, 1'b1);
    for (int i = 0; i < 12; i++) step(dv, 1'b0);

    // All channels change together
    for (int k = 0; k < 3; k++) begin
      dv = ~dv;
      for (int i = 0; i < 8; i++) step(dv, 1'b0);
    end

    // Randomized chatter with occasional resets
    for (int i = 0; i < 2000; i++) begin
      bit rst;
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(4) == 0) dv[ch] = ~dv[ch];
      rst = ($urandom_range(249) == 0);
      step(dv, rst);
    end
    for (int i = 0; i < 10; i++) step(dv, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
